// File: rtl/regdump_pkg.sv
// Shared types and default sizes for the register-file dump reader.
package regdump_pkg;

  localparam int unsigned NUM_REGS_DEFAULT = 32;
  localparam int unsigned ADDR_W_DEFAULT   = 5;
  localparam int unsigned DATA_W_DEFAULT   = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    SEND  = 3'd2,
    CKSUM = 3'd3,
    DONE  = 3'd4
  } regdump_state_e;

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Valid/ready stream from the dump reader to the debug/trace link.
interface regfile_dump_reader_if
  import regdump_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W = DATA_W_DEFAULT
);

  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [ADDR_W-1:0] m_index;
  logic              m_last;
  logic              m_cksum;

  modport master (
    output m_valid, m_data, m_index, m_last, m_cksum,
    input  m_ready
  );

  modport slave (
    input  m_valid, m_data, m_index, m_last, m_cksum,
    output m_ready
  );

endinterface

// File: rtl/regdump_cksum.sv
// XOR accumulator over captured dump words; clr has priority over en.
module regdump_cksum
  import regdump_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] acc
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc ^ d;
  end

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks the register file through one async read port and streams every value out.
// Build option: define REGDUMP_CHECKSUM_EN to append an XOR checksum word.
module regfile_dump_reader
  import regdump_pkg::*;
#(
  parameter int unsigned NUM_REGS = NUM_REGS_DEFAULT,
  parameter int unsigned ADDR_W   = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W   = DATA_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  hold_core,
  output logic                  done,
  output logic [ADDR_W-1:0]     rf_addr,
  input  logic [DATA_W-1:0]     rf_data,
  regfile_dump_reader_if.master m
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  regdump_state_e    state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic              last_q, last_d;
  logic              cksum_q, cksum_d;
  logic              capture_c;
  logic              hs_c;

  assign hs_c = valid_q & m.m_ready;

`ifdef REGDUMP_CHECKSUM_EN
  logic              acc_clr_c;
  logic [DATA_W-1:0] acc;

  regdump_cksum #(.DATA_W(DATA_W)) u_cksum (
    .clk   (clk),
    .reset (reset),
    .clr   (acc_clr_c),
    .en    (capture_c),
    .d     (rf_data),
    .acc   (acc)
  );
`endif

  // Next-state and next-output logic; every register has a next value here.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    valid_d   = valid_q;
    data_d    = data_q;
    index_d   = index_q;
    last_d    = last_q;
    cksum_d   = cksum_q;
    capture_c = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
    acc_clr_c = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          ptr_d   = '0;
          busy_d  = 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
          acc_clr_c = 1'b1;
`endif
        end
      end
      FETCH: begin
        capture_c = 1'b1;
        valid_d   = 1'b1;
        state_d   = SEND;
      end
      SEND: begin
        if (hs_c) begin
          if (index_q != LAST_IDX) begin
            capture_c = 1'b1;
          end else begin
`ifdef REGDUMP_CHECKSUM_EN
            state_d = CKSUM;
            data_d  = acc;
            index_d = '0;
            last_d  = 1'b1;
            cksum_d = 1'b1;
`else
            state_d = DONE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
`endif
          end
        end
      end
`ifdef REGDUMP_CHECKSUM_EN
      CKSUM: begin
        if (hs_c) begin
          state_d = DONE;
          valid_d = 1'b0;
          last_d  = 1'b0;
          cksum_d = 1'b0;
          done_d  = 1'b1;
        end
      end
`endif
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Capture the word at ptr and advance; the wrapped pointer is never captured.
    if (capture_c) begin
      data_d  = rf_data;
      index_d = ptr_q;
      ptr_d   = (ptr_q == LAST_IDX) ? '0 : ptr_q + ADDR_W'(1);
`ifdef REGDUMP_CHECKSUM_EN
      last_d  = 1'b0;
`else
      last_d  = (ptr_q == LAST_IDX);
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      index_q <= '0;
      last_q  <= 1'b0;
      cksum_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      index_q <= index_d;
      last_q  <= last_d;
      cksum_q <= cksum_d;
    end
  end

  assign busy      = busy_q;
  assign hold_core = busy_q;
  assign done      = done_q;
  assign rf_addr   = ptr_q;
  assign m.m_valid = valid_q;
  assign m.m_data  = data_q;
  assign m.m_index = index_q;
  assign m.m_last  = last_q;
  assign m.m_cksum = cksum_q;

endmodule
